// File: rtl/ysyx_22041752_trap_seq.sv
// Trap/return sequencer for the execute stage: walks the shared CSR port through
// the mepc/mcause/mstatus/mtvec save sequence or the mret restore, then redirects.
//
// state        | meaning
// IDLE         | waiting for an exception, mret or interrupt from a valid instruction
// T_RD_STATUS  | trap: read mstatus
// T_W_EPC      | trap: write mepc
// T_W_CAUSE    | trap: write mcause
// T_W_STATUS   | trap: write updated mstatus
// T_RD_TVEC    | trap: read mtvec, compute handler address
// M_RD_STATUS  | mret: read mstatus
// M_W_STATUS   | mret: write restored mstatus
// M_RD_EPC     | mret: read mepc as return address
// REDIRECT     | one-cycle flush with redirect PC
module ysyx_22041752_trap_seq #(
  parameter int XLEN     = 64,
  parameter int PC_WD    = 64,
  parameter int NEXC     = 4,
  parameter int IRQ_CODE = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_valid_i,
  input  logic [PC_WD-1:0]  es_pc_i,
  input  logic [NEXC-1:0]   exc_req_i,
  input  logic [NEXC*5-1:0] exc_code_i,
  input  logic              mret_i,
  input  logic              irq_pending_i,
  output logic              busy_o,
  output logic              csr_sel_o,
  output logic              csr_we_o,
  output logic [11:0]       csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              flush_o,
  output logic [PC_WD-1:0]  flush_pc_o,
  output logic              trap_taken_o,
  output logic              mret_taken_o
);

  typedef enum logic [3:0] {
    IDLE, T_RD_STATUS, T_W_EPC, T_W_CAUSE, T_W_STATUS, T_RD_TVEC,
    M_RD_STATUS, M_W_STATUS, M_RD_EPC, REDIRECT
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  state_e           state_q, state_d;
  logic [PC_WD-1:0] pc_q, pc_d;
  logic [4:0]       code_q, code_d;
  logic             intr_q, intr_d;
  logic             is_mret_q, is_mret_d;
  logic [XLEN-1:0]  status_q, status_d;
  logic [PC_WD-1:0] target_q, target_d;

  logic             exc_any;
  logic [4:0]       exc_sel_code;
  logic             accept;
  logic             we_raw;
  logic [XLEN-1:0]  cause_w;
  logic [XLEN-1:0]  trap_status;
  logic [XLEN-1:0]  mret_status;
  logic [XLEN-1:0]  tvec_base;
  logic [XLEN-1:0]  trap_tgt;

  // Scan from the top so the lowest-index request overwrites the others.
  always_comb begin
    exc_sel_code = '0;
    for (int i = NEXC - 1; i >= 0; i--) begin
      if (exc_req_i[i]) exc_sel_code = exc_code_i[5*i +: 5];
    end
  end

  assign exc_any = |exc_req_i;
  assign accept  = !reset && (state_q == IDLE) && es_valid_i &&
                   (exc_any || mret_i || irq_pending_i);

  always_comb begin
    cause_w           = '0;
    cause_w[XLEN-1]   = intr_q;
    cause_w[4:0]      = code_q;
    trap_status       = status_q;
    trap_status[7]    = status_q[3];
    trap_status[3]    = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status       = status_q;
    mret_status[3]    = status_q[7];
    mret_status[7]    = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign tvec_base = {csr_rdata_i[XLEN-1:2], 2'b00};
  assign trap_tgt  = (csr_rdata_i[1:0] == 2'b01 && intr_q) ?
                     tvec_base + (XLEN'(code_q) << 2) : tvec_base;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    code_d       = code_q;
    intr_d       = intr_q;
    is_mret_d    = is_mret_q;
    status_d     = status_q;
    target_d     = target_q;
    we_raw       = 1'b0;
    csr_addr_o   = '0;
    csr_wdata_o  = '0;
    flush_o      = 1'b0;
    flush_pc_o   = '0;
    trap_taken_o = 1'b0;
    mret_taken_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pc_d = es_pc_i;
          if (exc_any) begin
            code_d    = exc_sel_code;
            intr_d    = 1'b0;
            is_mret_d = 1'b0;
            state_d   = T_RD_STATUS;
          end else if (mret_i) begin
            code_d    = '0;
            intr_d    = 1'b0;
            is_mret_d = 1'b1;
            state_d   = M_RD_STATUS;
          end else begin
            code_d    = 5'(IRQ_CODE);
            intr_d    = 1'b1;
            is_mret_d = 1'b0;
            state_d   = T_RD_STATUS;
          end
        end
      end
      T_RD_STATUS: begin
        csr_addr_o = CSR_MSTATUS;
        status_d   = csr_rdata_i;
        state_d    = T_W_EPC;
      end
      T_W_EPC: begin
        we_raw      = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = XLEN'(pc_q);
        state_d     = T_W_CAUSE;
      end
      T_W_CAUSE: begin
        we_raw      = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_wdata_o = cause_w;
        state_d     = T_W_STATUS;
      end
      T_W_STATUS: begin
        we_raw      = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = trap_status;
        state_d     = T_RD_TVEC;
      end
      T_RD_TVEC: begin
        csr_addr_o = CSR_MTVEC;
        target_d   = trap_tgt[PC_WD-1:0];
        state_d    = REDIRECT;
      end
      M_RD_STATUS: begin
        csr_addr_o = CSR_MSTATUS;
        status_d   = csr_rdata_i;
        state_d    = M_W_STATUS;
      end
      M_W_STATUS: begin
        we_raw      = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mret_status;
        state_d     = M_RD_EPC;
      end
      M_RD_EPC: begin
        csr_addr_o = CSR_MEPC;
        target_d   = csr_rdata_i[PC_WD-1:0];
        state_d    = REDIRECT;
      end
      REDIRECT: begin
        flush_o      = 1'b1;
        flush_pc_o   = target_q;
        trap_taken_o = !is_mret_q;
        mret_taken_o = is_mret_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins at the edge, so a write in flight must not land in the CSR file.
  assign csr_we_o  = we_raw && !reset;
  assign csr_sel_o = (state_q != IDLE);
  assign busy_o    = (state_q != IDLE) || accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      code_q    <= '0;
      intr_q    <= 1'b0;
      is_mret_q <= 1'b0;
      status_q  <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      intr_q    <= intr_d;
      is_mret_q <= is_mret_d;
      status_q  <= status_d;
      target_q  <= target_d;
    end
  end

endmodule
